// File: rtl/ssram_arbiter.sv
// ssram_arbiter
// Shares one single-port, write-first SSRAM (1-cycle read latency) between two
// requesters. At most one RAM access is issued per cycle. Ties are resolved
// round-robin with a bounded burst, so a port keeps the RAM for at most
// MAX_BURST consecutive grants while the other port is waiting.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request, write enable, word address, write data
//   a_gnt                      port A access accepted this cycle
//   a_rvalid/a_rdata           port A read data valid (cycle after grant) / data
//   b_*                        same as port A, for port B
//   ram_en/ram_we              RAM enable / write enable
//   ram_addr/ram_din           RAM address / write data
//   ram_dout                   RAM read data (valid the cycle after the access)
module ssram_arbiter #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [WORD_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [WORD_WIDTH-1:0] b_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_din,
    input  logic [WORD_WIDTH-1:0] ram_dout
);

    localparam int unsigned CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic {
        OwnerA = 1'b0,
        OwnerB = 1'b1
    } owner_e;

    owner_e           r_last_owner;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rd_pend_a;
    logic             r_rd_pend_b;

    owner_e           w_last_owner_nxt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_keep_owner;

    // A non-zero count means the last owner was also granted in the previous cycle.
    assign w_keep_owner = (r_burst_cnt != '0) && (r_burst_cnt < MAX_CNT);

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (a_req && !b_req) begin
            w_gnt_a = 1'b1;
        end else if (b_req && !a_req) begin
            w_gnt_b = 1'b1;
        end else if (a_req && b_req) begin
            if (w_keep_owner) begin
                w_gnt_a = (r_last_owner == OwnerA);
                w_gnt_b = (r_last_owner == OwnerB);
            end else begin
                w_gnt_a = (r_last_owner == OwnerB);
                w_gnt_b = (r_last_owner == OwnerA);
            end
        end
        // Grants are gated so nothing reaches the RAM while reset is held.
        if (!rst_n) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end
    end

    assign a_gnt    = w_gnt_a;
    assign b_gnt    = w_gnt_b;
    assign ram_en   = w_gnt_a | w_gnt_b;
    assign ram_we   = w_gnt_b ? b_we    : (w_gnt_a & a_we);
    // Idle cycles present port A's address/data so the bus is deterministic.
    assign ram_addr = w_gnt_b ? b_addr  : a_addr;
    assign ram_din  = w_gnt_b ? b_wdata : a_wdata;

    always_comb begin
        w_last_owner_nxt = r_last_owner;
        w_burst_cnt_nxt  = '0;
        if (w_gnt_a || w_gnt_b) begin
            if ((w_gnt_b && (r_last_owner == OwnerB)) || (w_gnt_a && (r_last_owner == OwnerA))) begin
                w_burst_cnt_nxt = (r_burst_cnt < MAX_CNT) ? r_burst_cnt + 1'b1 : r_burst_cnt;
            end else begin
                w_last_owner_nxt = w_gnt_b ? OwnerB : OwnerA;
                w_burst_cnt_nxt  = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OwnerB;
            r_burst_cnt  <= '0;
            r_rd_pend_a  <= 1'b0;
            r_rd_pend_b  <= 1'b0;
        end else begin
            r_last_owner <= w_last_owner_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_rd_pend_a  <= w_gnt_a & ~a_we;
            r_rd_pend_b  <= w_gnt_b & ~b_we;
        end
    end

    assign a_rvalid = r_rd_pend_a;
    assign b_rvalid = r_rd_pend_b;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
Two-requester arbiter sharing one single-port synchronous write-first SSRAM (1-cycle read latency, en/we/addr/din/dout interface).
Issues at most one RAM access per cycle. Tied requests are resolved round-robin, with a bounded burst so neither port starves.
Sits between the AHB-to-SSRAM bridge (port A) and a secondary master such as a DMA or debug loader (port B), and the RAM instance.

Parameters:
WORD_WIDTH, 16, data width of RAM and both ports
ADDR_WIDTH, 10, word address width
MAX_BURST, 4, max consecutive grants to one port while the other is requesting (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req  in  1  port A access request
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_WIDTH  port A word address
a_wdata  in  WORD_WIDTH  port A write data
a_gnt  out  1  port A access accepted this cycle
a_rvalid  out  1  port A read data valid
a_rdata  out  WORD_WIDTH  port A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_din  out  WORD_WIDTH  RAM write data
ram_dout  in  WORD_WIDTH  RAM read data (registered in RAM, valid cycle after access)

Behaviour:
- State: last_owner (0=A, 1=B), burst_cnt (saturating, 0..MAX_BURST), rd_pend_a, rd_pend_b.
- Reset values: last_owner=B (A wins first tie), burst_cnt=0, rd_pend_*=0, a_rvalid=b_rvalid=0. While rst_n=0, a_gnt=b_gnt=0, ram_en=0, ram_we=0.
- Grant is combinational from req + state. At most one gnt per cycle.
  - Only one req high -> grant it.
  - Both high, owner granted previous cycle and burst_cnt<MAX_BURST -> grant owner.
  - Both high, otherwise -> grant the port that is not last_owner.
  - Neither high -> no grant, ram_en=0.
- On grant: ram_en=1; ram_we, ram_addr and ram_din are muxed from the granted port. RAM samples them at the next rising edge.
- When no grant: ram_we=0. ram_addr/ram_din hold the port A values (don't-care, but deterministic).
- Registered updates at each edge:
  - Grant to last_owner (consecutive) -> burst_cnt=min(burst_cnt+1, MAX_BURST).
  - Grant to the other port -> last_owner flips, burst_cnt=1.
  - No grant -> burst_cnt=0, last_owner unchanged.
- Read latency: read granted in cycle N -> x_rvalid=1 in cycle N+1 only, with x_rdata = ram_dout.
  - a_rdata and b_rdata both carry ram_dout. Data is meaningful only when the matching rvalid is high.
  - Writes never raise rvalid.
- Back-to-back reads from either or both ports: one rvalid per granted read, in grant order, no bubbles.
- Write then read of the same address on consecutive cycles returns the new data (RAM is write-first).
- Requesters hold req/we/addr/wdata stable until gnt. A req deasserted without gnt is simply dropped.
- MAX_BURST=1 -> strict alternation under continuous contention.
- Reset asserted mid-operation: gnt/ram_en drop immediately and rd_pend_* clear. A read granted in the previous cycle produces no rvalid.

Test Plan:
- Only A reads addr 0x005 after B writes 0x005=0xBEEF -> b_gnt cycle N, a_gnt cycle N+1, a_rvalid cycle N+2 with a_rdata=0xBEEF; b_rvalid never set.
- A and B both request continuously from reset, MAX_BURST=4 -> grant pattern AAAABBBBAAAA...; never >4 consecutive grants to one port.
- Same, MAX_BURST=1 -> ABABAB...; each read returns rvalid exactly one cycle after its grant on the correct port.
- A requests alone for 6 cycles, then B joins -> A holds until burst_cnt reaches 4 (counted from A's first grant), then B is granted; idle cycle resets burst_cnt to 0.
- A write 0x00A=0x1234 at cycle N, A read 0x00A at N+1 -> a_rvalid at N+2, a_rdata=0x1234.
- Read granted, rst_n pulled low next cycle -> a_rvalid stays 0, gnt/ram_en 0 during reset; after release first tie goes to A.
